// File: rtl/usb_tx_sequencer.sv
// USB packet transmit sequencer: emits SYNC, then LSB-first payload bits to the bit stuffer, then requests EOP.
// First SYNC bit the cycle after tx_start; one bit per cycle unless bs_stall holds the presented bit.
module usb_tx_sequencer (
    input  logic       clk,
    input  logic       RST,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       bs_bit,
    output logic       bs_en,
    input  logic       bs_stall,
    output logic       bs_clr,
    output logic       eop_req,
    input  logic       eop_done,
    output logic       busy,
    output logic       err_underrun
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC     = 3'd1,
        DATA     = 3'd2,
        EOP      = 3'd3,
        EOP_WAIT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  sr_q, sr_d;
    logic        last_q, last_d;
    logic        consume;
    logic        load;

    assign bs_en   = (state_q == SYNC) || (state_q == DATA);
    assign eop_req = (state_q == EOP);
    assign busy    = (state_q != IDLE);
    // SYNC is 0x80 sent LSB first: only the eighth bit is a one.
    assign bs_bit  = (state_q == SYNC) ? (bcnt_q == 3'd7) :
                     (state_q == DATA) ? sr_q[0] : 1'b0;

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        sr_d         = sr_q;
        last_d       = last_q;
        tx_ready     = 1'b0;
        bs_clr       = 1'b0;
        err_underrun = 1'b0;
        consume      = bs_en && !bs_stall;
        // The next byte is fetched exactly as the final bit of SYNC or of a non-final byte leaves.
        load         = consume && (bcnt_q == 3'd7) &&
                       ((state_q == SYNC) || ((state_q == DATA) && !last_q));

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    bs_clr  = 1'b1;
                    bcnt_d  = 3'd0;
                    last_d  = 1'b0;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (consume) begin
                    bcnt_d = bcnt_q + 3'd1;
                end
            end
            DATA: begin
                if (consume) begin
                    sr_d   = {1'b0, sr_q[7:1]};
                    bcnt_d = bcnt_q + 3'd1;
                    if ((bcnt_q == 3'd7) && last_q) begin
                        state_d = EOP;
                    end
                end
            end
            EOP: begin
                state_d = EOP_WAIT;
            end
            EOP_WAIT: begin
                if (eop_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            tx_ready = 1'b1;
            if (tx_valid) begin
                sr_d    = tx_data;
                last_d  = tx_last;
                bcnt_d  = 3'd0;
                state_d = DATA;
            end else begin
                err_underrun = 1'b1;
                state_d      = EOP;
            end
        end

        if (RST) begin
            tx_ready     = 1'b0;
            bs_clr       = 1'b0;
            err_underrun = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            bcnt_q  <= 3'd0;
            sr_q    <= 8'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            sr_q    <= sr_d;
            last_q  <= last_d;
        end
    end

endmodule
